serial_acc_bank: RTL and testbench

- Receiving end of the controller's bit-serial link (`tx` data bit + `acc` strobe).
- Deserialises the MSB-first stream into bytes and stores them in a 16-entry circular register bank.
- Any entry can be read back through a 4-bit select, so the controller's readback loop can return results over the UART.
- Reports fill level, overflow and framing-error status in an 8-bit status word.

---
 rtl/serial_acc_bank_if.sv | 28 ++
 rtl/serial_acc_bank.sv | 166 ++++++++++++++++
 tb/tb_serial_acc_bank.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_acc_bank_if.sv
// serial_acc_bank_if: bundles the bit-serial link, control and readback signals of serial_acc_bank.
// Ports (master = controller side): bit_in, bit_valid, clear, sel drive the bank;
// data_out, byte_out, byte_valid, frame_err, count, status come back from it.
interface serial_acc_bank_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  logic                       bit_in;
  logic                       bit_valid;
  logic                       clear;
  logic [$clog2(DEPTH)-1:0]   sel;
  logic [WIDTH-1:0]           data_out;
  logic [WIDTH-1:0]           byte_out;
  logic                       byte_valid;
  logic                       frame_err;
  logic [$clog2(DEPTH):0]     count;
  logic [7:0]                 status;

  modport master (
    output bit_in, bit_valid, clear, sel,
    input  data_out, byte_out, byte_valid, frame_err, count, status
  );

  modport slave (
    input  bit_in, bit_valid, clear, sel,
    output data_out, byte_out, byte_valid, frame_err, count, status
  );
endinterface

// File: rtl/serial_acc_bank.sv
// serial_acc_bank: deserialises an MSB-first bit stream into bytes stored in a circular register bank.
// Latency: byte_valid/byte_out one cycle after the 8th strobe; data_out one cycle after sel.
// Backpressure: none -- every strobe is accepted, a full bank overwrites its oldest entry (ovf).
// Ports: clk, nRst (sync, active-low); bus (slave modport) carries bit_in/bit_valid/clear/sel in and
// data_out/byte_out/byte_valid/frame_err/count/status out.
module serial_acc_bank #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                nRst,
  serial_acc_bank_if.slave    bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int BW   = $clog2(WIDTH);
  localparam int TW   = $clog2(TIMEOUT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic [7:0] STATUS_RST = 8'h10;

  // state
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sh;
  logic [BW-1:0]    r_bit_cnt;
  logic [TW-1:0]    r_idle;
  logic [PW-1:0]    r_wr_ptr;
  logic [CNTW-1:0]  r_count;
  logic             r_ovf;
  logic             r_ferr;
  logic [WIDTH-1:0] r_bank [DEPTH];
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_byte_out;
  logic             r_byte_valid;
  logic             r_frame_err;
  logic [7:0]       r_status;

  // next-state
  logic [0:0]       w_state_n;
  logic [WIDTH-1:0] w_sh_n;
  logic [BW-1:0]    w_bit_cnt_n;
  logic [TW-1:0]    w_idle_n;
  logic [CNTW-1:0]  w_count_n;
  logic             w_ovf_n;
  logic             w_ferr_n;
  logic             w_wr;
  logic             w_tmo;
  logic             w_full;
  logic [WIDTH-1:0] w_assembled;
  logic [7:0]       w_status_n;

  assign w_assembled = {r_sh[WIDTH-2:0], bus.bit_in};
  assign w_full      = (r_count == CNTW'(DEPTH));

  always_comb begin
    w_state_n   = r_state;
    w_sh_n      = r_sh;
    w_bit_cnt_n = r_bit_cnt;
    w_idle_n    = r_idle;
    w_wr        = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Idle counter is frozen here: waiting for the first bit is not a framing problem.
        if (bus.bit_valid) begin
          w_sh_n      = w_assembled;
          w_bit_cnt_n = BW'(1);
          w_idle_n    = '0;
          w_state_n   = ST_RECV;
        end
      end
      default: begin
        if (bus.bit_valid) begin
          w_sh_n   = w_assembled;
          w_idle_n = '0;
          if (r_bit_cnt == BW'(WIDTH - 1)) begin
            w_wr        = 1'b1;
            w_bit_cnt_n = '0;
            w_state_n   = ST_IDLE;
          end else begin
            w_bit_cnt_n = r_bit_cnt + BW'(1);
          end
        end else if (r_idle == TW'(TIMEOUT - 1)) begin
          // Counter already shows TIMEOUT-1 idle cycles: this idle cycle is the last one allowed.
          w_tmo       = 1'b1;
          w_sh_n      = '0;
          w_bit_cnt_n = '0;
          w_idle_n    = '0;
          w_state_n   = ST_IDLE;
        end else begin
          w_idle_n = r_idle + TW'(1);
        end
      end
    endcase
  end

  // Fill level saturates; a write into a full bank replaces the oldest entry and flags overflow.
  always_comb begin
    w_count_n = r_count;
    w_ovf_n   = r_ovf;
    w_ferr_n  = r_ferr | w_tmo;
    if (w_wr) begin
      if (w_full) begin
        w_ovf_n = 1'b1;
      end else begin
        w_count_n = r_count + CNTW'(1);
      end
    end
  end

  // Status is built from next-state values so the register reflects the state after this edge.
  assign w_status_n = {w_ovf_n, w_ferr_n, (w_count_n == CNTW'(DEPTH)),
                       (w_count_n == '0), 1'b0, w_bit_cnt_n};

  always_ff @(posedge clk) begin
    if (!nRst || bus.clear) begin
      // clear matches reset for everything it touches, and it wins over a same-cycle strobe.
      r_state      <= ST_IDLE;
      r_sh         <= '0;
      r_bit_cnt    <= '0;
      r_idle       <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_ferr       <= 1'b0;
      r_data_out   <= '0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_status     <= STATUS_RST;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_state      <= w_state_n;
      r_sh         <= w_sh_n;
      r_bit_cnt    <= w_bit_cnt_n;
      r_idle       <= w_idle_n;
      r_count      <= w_count_n;
      r_ovf        <= w_ovf_n;
      r_ferr       <= w_ferr_n;
      r_byte_valid <= w_wr;
      r_frame_err  <= w_tmo;
      r_status     <= w_status_n;
      // Read of the slot being written returns its old contents; new data shows next cycle.
      r_data_out   <= r_bank[bus.sel];
      if (w_wr) begin
        r_bank[r_wr_ptr] <= w_assembled;
        r_byte_out       <= w_assembled;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.byte_out   = r_byte_out;
  assign bus.byte_valid = r_byte_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.count      = r_count;
  assign bus.status     = r_status;

endmodule

// File: tb/tb_serial_acc_bank.sv
// tb_serial_acc_bank: directed bench for serial_acc_bank with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Ends with one TB_RESULT summary line.
module tb_serial_acc_bank;

  logic clk;
  logic nRst;
  int   checks;
  int   failures;
  int   cyc;
  int   ferr_pulses;
  int   t1;
  int   t2;
  int   p0;

  serial_acc_bank_if #(.DEPTH(16), .WIDTH(8)) bus ();

  serial_acc_bank #(.DEPTH(16), .WIDTH(8), .TIMEOUT(64)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.frame_err === 1'b1) ferr_pulses = ferr_pulses + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    ferr_pulses = 0;
    nRst          = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.clear     = 1'b0;
    bus.sel       = 4'd0;
    idle(2);

    // Reset state
    chk("rst_status",    32'(bus.status),     32'h10);
    chk("rst_count",     32'(bus.count),      32'd0);
    chk("rst_data_out",  32'(bus.data_out),   32'h00);
    chk("rst_byte_out",  32'(bus.byte_out),   32'h00);
    chk("rst_byte_vld",  32'(bus.byte_valid), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err),  32'd0);
    nRst = 1'b1;

    // Byte A5 with consecutive strobes; sel=0 reads old value on the write edge
    send_byte(8'hA5);
    chk("a5_byte_vld",   32'(bus.byte_valid), 32'd1);
    chk("a5_byte_out",   32'(bus.byte_out),   32'hA5);
    chk("a5_count",      32'(bus.count),      32'd1);
    chk("a5_status",     32'(bus.status),     32'h00);
    chk("a5_rd_old",     32'(bus.data_out),   32'h00);
    tick();
    chk("a5_rd_new",     32'(bus.data_out),   32'hA5);
    chk("a5_vld_pulse",  32'(bus.byte_valid), 32'd0);

    // Byte 3C with 10-cycle spacing between strobes: no timeout
    p0 = ferr_pulses;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'h3C;
      send_bit(v[i]);
      if (i > 0) idle(9);
    end
    chk("gap_byte_vld",  32'(bus.byte_valid), 32'd1);
    chk("gap_byte_out",  32'(bus.byte_out),   32'h3C);
    chk("gap_no_ferr",   32'(ferr_pulses - p0), 32'd0);
    chk("gap_count",     32'(bus.count),      32'd2);

    // Two bytes back-to-back: pulses exactly 8 cycles apart
    send_byte(8'h12);
    t1 = cyc;
    chk("b2b_vld1",      32'(bus.byte_valid), 32'd1);
    send_byte(8'h34);
    t2 = cyc;
    chk("b2b_vld2",      32'(bus.byte_valid), 32'd1);
    chk("b2b_spacing",   32'(t2 - t1),        32'd8);
    chk("b2b_byte_out",  32'(bus.byte_out),   32'h34);
    chk("b2b_count",     32'(bus.count),      32'd4);

    // Fill and wrap: 17 bytes 00..10
    do_clear();
    chk("clr1_count",    32'(bus.count),      32'd0);
    chk("clr1_status",   32'(bus.status),     32'h10);
    for (int k = 0; k < 17; k++) send_byte(8'(k));
    chk("wrap_count",    32'(bus.count),      32'd16);
    chk("wrap_flags",    32'(bus.status[7:5]), 32'b101);
    chk("wrap_status",   32'(bus.status),     32'hA0);
    bus.sel = 4'd0;
    tick();
    chk("wrap_rd0",      32'(bus.data_out),   32'h10);
    bus.sel = 4'd1;
    tick();
    chk("wrap_rd1",      32'(bus.data_out),   32'h01);
    bus.sel = 4'd15;
    tick();
    chk("wrap_rd15",     32'(bus.data_out),   32'h0F);

    // Timeout: 3 bits then idle; discard on the 64th idle cycle
    do_clear();
    p0 = ferr_pulses;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("tmo_partial",   32'(bus.status),     32'h13);
    idle(63);
    chk("tmo_not_yet",   32'(bus.frame_err),  32'd0);
    chk("tmo_status_pre", 32'(bus.status),    32'h13);
    idle(1);
    chk("tmo_pulse",     32'(bus.frame_err),  32'd1);
    chk("tmo_status",    32'(bus.status),     32'h50);
    idle(3);
    chk("tmo_pulse_end", 32'(bus.frame_err),  32'd0);
    chk("tmo_once",      32'(ferr_pulses - p0), 32'd1);
    send_byte(8'hFF);
    chk("tmo_ff_out",    32'(bus.byte_out),   32'hFF);
    chk("tmo_ff_count",  32'(bus.count),      32'd1);
    chk("tmo_ff_status", 32'(bus.status),     32'h40);

    // clear beats a simultaneous strobe
    do_clear();
    for (int k = 0; k < 5; k++) send_byte(8'h11 + 8'(k));
    chk("clr_pre_count", 32'(bus.count),      32'd5);
    bus.clear     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    tick();
    bus.clear     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    chk("clr_count",     32'(bus.count),      32'd0);
    chk("clr_status",    32'(bus.status),     32'h10);
    chk("clr_byte_out",  32'(bus.byte_out),   32'h00);
    for (int k = 0; k < 5; k++) begin
      bus.sel = 4'(k);
      tick();
      chk($sformatf("clr_rd%0d", k), 32'(bus.data_out), 32'h00);
    end
    bus.sel = 4'd0;
    send_byte(8'h5A);
    chk("clr_next_vld",  32'(bus.byte_valid), 32'd1);
    chk("clr_next_out",  32'(bus.byte_out),   32'h5A);
    chk("clr_next_cnt",  32'(bus.count),      32'd1);
    tick();
    chk("clr_next_rd0",  32'(bus.data_out),   32'h5A);

    // Reset mid-byte
    p0 = ferr_pulses;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("mid_status",    32'(bus.status),     32'h04);
    nRst = 1'b0;
    tick();
    nRst = 1'b1;
    chk("mrst_status",   32'(bus.status),     32'h10);
    chk("mrst_count",    32'(bus.count),      32'd0);
    chk("mrst_byte_out", 32'(bus.byte_out),   32'h00);
    chk("mrst_data_out", 32'(bus.data_out),   32'h00);
    chk("mrst_byte_vld", 32'(bus.byte_valid), 32'd0);
    send_byte(8'h81);
    chk("mrst_81_vld",   32'(bus.byte_valid), 32'd1);
    chk("mrst_81_out",   32'(bus.byte_out),   32'h81);
    chk("mrst_81_count", 32'(bus.count),      32'd1);
    tick();
    chk("mrst_81_rd0",   32'(bus.data_out),   32'h81);
    chk("mrst_no_ferr",  32'(ferr_pulses - p0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
